// File: rtl/sprite_motion_engine_pkg.sv
// Shared types and constants for the sprite motion engine: sweep FSM states,
// per-channel motion modes and the default coordinate width.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;

    localparam int COORD_W_DEF = 16;

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Host write port of the sprite motion engine: loads position, velocity and
// mode of one channel per strobe.
interface sprite_motion_engine_if #(
    parameter int COORD_W = 16
);
    logic                      wr_en;
    logic [3:0]                wr_ch;
    logic signed [COORD_W-1:0] wr_x;
    logic signed [COORD_W-1:0] wr_y;
    logic signed [COORD_W-1:0] wr_vel_x;
    logic signed [COORD_W-1:0] wr_vel_y;
    logic                      wr_mode;

    modport master (
        output wr_en, wr_ch, wr_x, wr_y, wr_vel_x, wr_vel_y, wr_mode
    );

    modport slave (
        input wr_en, wr_ch, wr_x, wr_y, wr_vel_x, wr_vel_y, wr_mode
    );
endinterface

// File: rtl/sprite_motion_engine_axis_step.sv
// One-axis motion step: advances a position by its velocity and either
// reflects at or wraps around the [0, bound) range.
module motion_axis_step
    import motion_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic signed [COORD_W-1:0] pos_i,
    input  logic signed [COORD_W-1:0] vel_i,
    input  logic                      mode_i,
    input  logic signed [COORD_W:0]   bound_i,
    output logic signed [COORD_W-1:0] pos_o,
    output logic signed [COORD_W-1:0] vel_o,
    output logic                      hit_o
);

    // The most negative velocity has no positive twin, so reflection clamps it.
    function automatic logic signed [COORD_W-1:0] neg_sat(input logic signed [COORD_W-1:0] v);
        logic signed [COORD_W-1:0] most_neg;
        most_neg = {1'b1, {(COORD_W-1){1'b0}}};
        if (v == most_neg) begin
            neg_sat = {1'b0, {(COORD_W-1){1'b1}}};
        end else begin
            neg_sat = -v;
        end
    endfunction

    logic signed [COORD_W:0] nxt_s;
    logic signed [COORD_W:0] adj_s;

    // Step computation with one guard bit so overshoot in either direction is visible.
    always_comb begin
        nxt_s = {pos_i[COORD_W-1], pos_i} + {vel_i[COORD_W-1], vel_i};
        adj_s = nxt_s;
        pos_o = nxt_s[COORD_W-1:0];
        vel_o = vel_i;
        hit_o = 1'b0;
        if (nxt_s >= bound_i) begin
            hit_o = 1'b1;
            if (mode_i == MODE_WRAP) begin
                adj_s = nxt_s - bound_i;
            end else begin
                adj_s = bound_i - {{COORD_W{1'b0}}, 1'b1};
                vel_o = neg_sat(vel_i);
            end
            pos_o = adj_s[COORD_W-1:0];
        end else if (nxt_s[COORD_W]) begin
            hit_o = 1'b1;
            if (mode_i == MODE_WRAP) begin
                adj_s = nxt_s + bound_i;
            end else begin
                adj_s = {(COORD_W+1){1'b0}};
                vel_o = neg_sat(vel_i);
            end
            pos_o = adj_s[COORD_W-1:0];
        end else begin
            pos_o = nxt_s[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/sprite_motion_engine.sv
// Multi-channel sprite/scroll motion engine: steps every channel once per
// (i_frame_div+1) vsync edges. Optional macro SPRITE_MOTION_EDGE_FLAGS_EN adds o_edge_hit.
module sprite_motion_engine
    import motion_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int COORD_W = COORD_W_DEF,
    parameter int DIV_W   = 3,
    parameter int MAX_X   = 800,
    parameter int MAX_Y   = 150
) (
    input  logic                        i_pix_clk,
    input  logic                        i_reset,
    input  logic                        i_vert_sync,
    input  logic [DIV_W-1:0]            i_frame_div,
    sprite_motion_engine_if.slave       wr_if,
    output logic [NUM_CH*COORD_W-1:0]   o_x_coords,
    output logic [NUM_CH*COORD_W-1:0]   o_y_coords,
    output logic                        o_busy,
    output logic                        o_update_done
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
    ,
    output logic [NUM_CH-1:0]           o_edge_hit
`endif
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic signed [COORD_W:0] BOUND_X = (COORD_W+1)'(MAX_X);
    localparam logic signed [COORD_W:0] BOUND_Y = (COORD_W+1)'(MAX_Y);

    logic               vs_q;
    logic [DIV_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               trig_q, trig_d;
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               vs_edge_s;
    logic               step_en_s;
    logic               wr_valid_s;

    logic signed [COORD_W-1:0] pos_x_q [NUM_CH];
    logic signed [COORD_W-1:0] pos_y_q [NUM_CH];
    logic signed [COORD_W-1:0] vel_x_q [NUM_CH];
    logic signed [COORD_W-1:0] vel_y_q [NUM_CH];
    logic [NUM_CH-1:0]         mode_q;

    logic signed [COORD_W-1:0] step_pos_x_s, step_vel_x_s, step_pos_y_s, step_vel_y_s;
    logic                      hit_x_s, hit_y_s;

    // Frame divider: counts vsync rising edges and raises a one-cycle sweep request.
    always_comb begin
        vs_edge_s   = i_vert_sync & ~vs_q;
        frame_cnt_d = frame_cnt_q;
        trig_d      = 1'b0;
        if (vs_edge_s) begin
            if (frame_cnt_q == i_frame_div) begin
                frame_cnt_d = {DIV_W{1'b0}};
                trig_d      = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Sweep FSM next-state; a request arriving outside IDLE is simply dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        step_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_q) begin
                    state_d = SWEEP;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                step_en_s = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Control registers.
    always_ff @(posedge i_pix_clk or posedge i_reset) begin
        if (i_reset) begin
            vs_q        <= 1'b0;
            frame_cnt_q <= {DIV_W{1'b0}};
            trig_q      <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vs_q        <= i_vert_sync;
            frame_cnt_q <= frame_cnt_d;
            trig_q      <= trig_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    motion_axis_step #(.COORD_W(COORD_W)) u_step_x (
        .pos_i   (pos_x_q[idx_q]),
        .vel_i   (vel_x_q[idx_q]),
        .mode_i  (mode_q[idx_q]),
        .bound_i (BOUND_X),
        .pos_o   (step_pos_x_s),
        .vel_o   (step_vel_x_s),
        .hit_o   (hit_x_s)
    );

    motion_axis_step #(.COORD_W(COORD_W)) u_step_y (
        .pos_i   (pos_y_q[idx_q]),
        .vel_i   (vel_y_q[idx_q]),
        .mode_i  (mode_q[idx_q]),
        .bound_i (BOUND_Y),
        .pos_o   (step_pos_y_s),
        .vel_o   (step_vel_y_s),
        .hit_o   (hit_y_s)
    );

    assign wr_valid_s = wr_if.wr_en && ({1'b0, wr_if.wr_ch} < 5'(NUM_CH));

    // Channel state: a host write to the channel under sweep overrides the step result.
    always_ff @(posedge i_pix_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pos_x_q[k] <= {COORD_W{1'b0}};
                pos_y_q[k] <= {COORD_W{1'b0}};
                vel_x_q[k] <= {COORD_W{1'b0}};
                vel_y_q[k] <= {COORD_W{1'b0}};
                mode_q[k]  <= MODE_BOUNCE;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_valid_s && (wr_if.wr_ch == 4'(k))) begin
                    pos_x_q[k] <= wr_if.wr_x;
                    pos_y_q[k] <= wr_if.wr_y;
                    vel_x_q[k] <= wr_if.wr_vel_x;
                    vel_y_q[k] <= wr_if.wr_vel_y;
                    mode_q[k]  <= wr_if.wr_mode;
                end else if (step_en_s && (idx_q == IDX_W'(k))) begin
                    pos_x_q[k] <= step_pos_x_s;
                    pos_y_q[k] <= step_pos_y_s;
                    vel_x_q[k] <= step_vel_x_s;
                    vel_y_q[k] <= step_vel_y_s;
                end
            end
        end
    end

`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
    logic [NUM_CH-1:0] edge_hit_q;

    // Sticky per-channel boundary flags; a write to the channel clears its flag first.
    always_ff @(posedge i_pix_clk or posedge i_reset) begin
        if (i_reset) begin
            edge_hit_q <= {NUM_CH{1'b0}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_valid_s && (wr_if.wr_ch == 4'(k))) begin
                    edge_hit_q[k] <= 1'b0;
                end else if (step_en_s && (idx_q == IDX_W'(k)) && (hit_x_s || hit_y_s)) begin
                    edge_hit_q[k] <= 1'b1;
                end
            end
        end
    end

    assign o_edge_hit = edge_hit_q;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign o_x_coords[g*COORD_W +: COORD_W] = pos_x_q[g];
        assign o_y_coords[g*COORD_W +: COORD_W] = pos_y_q[g];
    end

    assign o_busy        = busy_q;
    assign o_update_done = done_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed scoreboard bench for sprite_motion_engine (NUM_CH=4, COORD_W=16).
module tb_sprite_motion_engine;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int LAT = NCH + 2;

    logic             clk;
    logic             rst;
    logic             vsync;
    logic [2:0]       frame_div;
    logic [NCH*CW-1:0] x_coords;
    logic [NCH*CW-1:0] y_coords;
    logic             busy;
    logic             upd_done;
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
    logic [NCH-1:0]   edge_hit;
`endif

    sprite_motion_engine_if #(.COORD_W(CW)) wr_if ();

    sprite_motion_engine #(
        .NUM_CH(NCH), .COORD_W(CW), .DIV_W(3), .MAX_X(800), .MAX_Y(150)
    ) dut (
        .i_pix_clk     (clk),
        .i_reset       (rst),
        .i_vert_sync   (vsync),
        .i_frame_div   (frame_div),
        .wr_if         (wr_if),
        .o_x_coords    (x_coords),
        .o_y_coords    (y_coords),
        .o_busy        (busy),
        .o_update_done (upd_done)
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
        ,
        .o_edge_hit    (edge_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          ch;
        bit          is_y;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int x, input int y, input int vx, input int vy, input bit mode);
        wr_if.wr_en    = 1'b1;
        wr_if.wr_ch    = 4'(ch);
        wr_if.wr_x     = 16'(x);
        wr_if.wr_y     = 16'(y);
        wr_if.wr_vel_x = 16'(vx);
        wr_if.wr_vel_y = 16'(vy);
        wr_if.wr_mode  = mode;
        tick();
        wr_if.wr_en    = 1'b0;
    endtask

    task automatic expect_pos(input string tag, input int ch, input bit is_y, input int v);
        sb_entry_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.is_y = is_y;
        e.exp  = 16'(v);
        sb.push_back(e);
    endtask

    task automatic drain_sb();
        sb_entry_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_y ? y_coords[e.ch*CW +: CW] : x_coords[e.ch*CW +: CW];
            chk(e.tag, {48'd0, obs}, {48'd0, e.exp});
        end
    endtask

    // Vsync edge that should not start a sweep.
    task automatic edge_only();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    // Vsync edge that starts a sweep; checks busy, latency and the scoreboard.
    task automatic run_frame(input string tag);
        int lat;
        bit seen;
        bit busy_seen;
        lat = 0;
        seen = 1'b0;
        busy_seen = 1'b0;
        vsync = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            vsync = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (upd_done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT));
        chk({tag, "_busy"}, {63'd0, busy_seen}, 64'd1);
        tick();
        drain_sb();
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1;
        vsync = 1'b0;
        frame_div = 3'd7;
        wr_if.wr_en = 1'b0;
        wr_if.wr_ch = 4'd0;
        wr_if.wr_x = 16'd0;
        wr_if.wr_y = 16'd0;
        wr_if.wr_vel_x = 16'd0;
        wr_if.wr_vel_y = 16'd0;
        wr_if.wr_mode = 1'b0;
        tick();
        tick();
        chk("reset_x", x_coords, 64'd0);
        chk("reset_y", y_coords, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, upd_done}, 64'd0);
        rst = 1'b0;
        tick();

        // Frame divider: eighth edge triggers when i_frame_div=7.
        wr(0, 0, 0, 2, 0, 1'b0);
        for (int i = 0; i < 7; i++) edge_only();
        chk("div_no_step_x0", {48'd0, x_coords[15:0]}, 64'd0);
        expect_pos("div_step_x0", 0, 1'b0, 2);
        run_frame("div");

        // Upper bounce, then reflected velocity.
        frame_div = 3'd0;
        wr(0, 2, 0, 0, 0, 1'b0);
        wr(1, 798, 0, 3, 0, 1'b0);
        expect_pos("bounce_hi_x1", 1, 1'b0, 799);
        run_frame("bounce1");
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
        chk("edge_set_ch1", {63'd0, edge_hit[1]}, 64'd1);
`endif
        expect_pos("bounce_back_x1", 1, 1'b0, 796);
        run_frame("bounce2");

        // Lower bounce.
        wr(1, 1, 0, -4, 0, 1'b0);
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
        chk("edge_clr_ch1", {63'd0, edge_hit[1]}, 64'd0);
`endif
        expect_pos("bounce_lo_x1", 1, 1'b0, 0);
        run_frame("lo1");
        expect_pos("bounce_lo_back_x1", 1, 1'b0, 4);
        run_frame("lo2");

        // Wrap in both directions; velocity keeps its sign.
        wr(1, 4, 0, 0, 0, 1'b0);
        wr(2, 0, 148, 0, 5, 1'b1);
        expect_pos("wrap_hi_y2", 2, 1'b1, 3);
        run_frame("wrap1");
        wr(2, 0, 2, 0, -5, 1'b1);
        expect_pos("wrap_lo_y2", 2, 1'b1, 147);
        run_frame("wrap2");
        expect_pos("wrap_vel_kept_y2", 2, 1'b1, 142);
        run_frame("wrap3");
        wr(2, 0, 142, 0, 0, 1'b1);

        // Host write collides with the sweep of channel 3.
        wr(3, 10, 0, 1, 0, 1'b0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wr(3, 100, 0, 2, 0, 1'b0);
        chk("collide_done", {63'd0, upd_done}, 64'd1);
        tick();
        expect_pos("collide_x3", 3, 1'b0, 100);
        drain_sb();

        // Out-of-range channel index changes nothing.
        wr(15, 555, 555, 1, 1, 1'b1);
        tick();
        chk("wr_ch15_x", x_coords, {16'd100, 16'd0, 16'd4, 16'd2});
        chk("wr_ch15_y", y_coords, {16'd0, 16'd142, 16'd0, 16'd0});

        // Reset in the middle of a sweep.
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_x", x_coords, 64'd0);
        chk("midrst_y", y_coords, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
`ifdef SPRITE_MOTION_EDGE_FLAGS_EN
        chk("midrst_edge", {60'd0, edge_hit}, 64'd0);
`endif
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (upd_done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {63'd0, saw_done}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
